// File: rtl/result_queue.sv
// rtl/result_queue.sv - Result FIFO with bus-mapped head/status/control, drop accounting and level irq.
module result_queue #(
    parameter int DEPTH      = 4,
    parameter int IRQ_THRESH = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [31:0] res_w,
    input  logic [5:0]  res_l,
    input  logic        res_ovf,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [15:0] ADDR_HEAD_W = 16'h03B0;
    localparam logic [15:0] ADDR_HEAD_L = 16'h03B8;
    localparam logic [15:0] ADDR_STATUS = 16'h03C0;
    localparam logic [15:0] ADDR_CTRL   = 16'h03C8;

    logic [38:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          sticky_q, sticky_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic          srd_q, swr_q;
    logic          srd_arm_q, swr_arm_q;
    logic [31:0]   sdata_out_q, sdata_out_d;
    logic          irq_q, irq_d;

    logic        full, empty;
    logic        rd_ev, wr_ev, ctrl_wr;
    logic        pop_req, flush_req, clr_req;
    logic        pop_eff, push_eff, drop_eff;
    logic [38:0] head;

    assign full  = (count_q == 5'(DEPTH));
    assign empty = (count_q == 5'd0);
    assign head  = mem_q[rd_ptr_q];

    // Arm flags make a strobe still high when reset releases wait for a fresh rising edge.
    assign rd_ev   = srd & ~srd_q & srd_arm_q;
    assign wr_ev   = swr & ~swr_q & swr_arm_q;
    assign ctrl_wr = wr_ev && (saddress == ADDR_CTRL);

    assign pop_req   = ctrl_wr & sdata_in[0];
    assign flush_req = ctrl_wr & sdata_in[1];
    assign clr_req   = ctrl_wr & sdata_in[2];

    assign pop_eff  = pop_req & ~empty & ~flush_req;
    assign push_eff = res_valid & (~full | pop_eff) & ~flush_req;
    assign drop_eff = res_valid & full & ~pop_eff & ~flush_req;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        sticky_d   = sticky_q;
        drop_cnt_d = drop_cnt_q;

        if (flush_req) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = 5'd0;
        end else begin
            if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
            if (push_eff && !pop_eff)      count_d = count_q + 5'd1;
            else if (pop_eff && !push_eff) count_d = count_q - 5'd1;
        end

        if (clr_req) begin
            sticky_d   = 1'b0;
            drop_cnt_d = 8'd0;
        end else if (drop_eff) begin
            sticky_d = 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end

        irq_d = (IRQ_THRESH != 0) && (count_d >= 5'(IRQ_THRESH));
    end

    // Read data reflects state before any CTRL write landing on the same edge.
    always_comb begin
        sdata_out_d = sdata_out_q;
        if (rd_ev) begin
            case (saddress)
                ADDR_HEAD_W: sdata_out_d = empty ? 32'd0 : head[31:0];
                ADDR_HEAD_L: sdata_out_d = empty ? 32'd0 : {25'd0, head[38:32]};
                ADDR_STATUS: sdata_out_d = {8'd0, drop_cnt_q, 5'd0, sticky_q, full, empty, 3'd0, count_q};
                default:     sdata_out_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= 5'd0;
            sticky_q    <= 1'b0;
            drop_cnt_q  <= 8'd0;
            srd_q       <= 1'b0;
            swr_q       <= 1'b0;
            srd_arm_q   <= 1'b0;
            swr_arm_q   <= 1'b0;
            sdata_out_q <= 32'd0;
            irq_q       <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            sticky_q    <= sticky_d;
            drop_cnt_q  <= drop_cnt_d;
            srd_q       <= srd;
            swr_q       <= swr;
            srd_arm_q   <= srd_arm_q | ~srd;
            swr_arm_q   <= swr_arm_q | ~swr;
            sdata_out_q <= sdata_out_d;
            irq_q       <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) mem_q[wr_ptr_q] <= {res_ovf, res_l, res_w};
    end

    assign res_ready = ~full;
    assign sdata_out = sdata_out_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_result_queue.sv
// tb/tb_result_queue.sv - Directed scoreboard bench for result_queue.
module tb_result_queue;

    localparam int DEPTH      = 4;
    localparam int IRQ_THRESH = 1;

    localparam logic [15:0] A_HW   = 16'h03B0;
    localparam logic [15:0] A_HL   = 16'h03B8;
    localparam logic [15:0] A_STAT = 16'h03C0;
    localparam logic [15:0] A_CTRL = 16'h03C8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [31:0] res_w = '0;
    logic [5:0]  res_l = '0;
    logic        res_ovf = 1'b0;
    logic [15:0] saddress = '0;
    logic        srd = 1'b0;
    logic        swr = 1'b0;
    logic [31:0] sdata_in = '0;
    logic [31:0] sdata_out;
    logic        irq;

    result_queue #(.DEPTH(DEPTH), .IRQ_THRESH(IRQ_THRESH)) dut (
        .clk(clk), .reset(reset), .res_valid(res_valid), .res_ready(res_ready),
        .res_w(res_w), .res_l(res_l), .res_ovf(res_ovf),
        .saddress(saddress), .srd(srd), .swr(swr), .sdata_in(sdata_in),
        .sdata_out(sdata_out), .irq(irq)
    );

    always #5 clk = ~clk;

    logic [38:0] sb[$];
    logic        m_sticky = 1'b0;
    int          m_dcnt = 0;
    int          n_checks = 0;
    int          n_fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [4:0] c;
        logic [7:0] d;
        c = 5'(sb.size());
        d = 8'(m_dcnt);
        return {8'd0, d, 5'd0, m_sticky, (sb.size() == DEPTH), (sb.size() == 0), 3'd0, c};
    endfunction

    function automatic logic [31:0] m_head_w();
        logic [38:0] e;
        if (sb.size() == 0) return 32'd0;
        e = sb[0];
        return e[31:0];
    endfunction

    function automatic logic [31:0] m_head_l();
        logic [38:0] e;
        if (sb.size() == 0) return 32'd0;
        e = sb[0];
        return {25'd0, e[38:32]};
    endfunction

    task automatic m_push(input logic [31:0] w, input logic [5:0] l, input logic o);
        if (sb.size() < DEPTH) sb.push_back({o, l, w});
        else begin
            m_sticky = 1'b1;
            if (m_dcnt != 255) m_dcnt++;
        end
    endtask

    task automatic drive_res(input logic [31:0] w, input logic [5:0] l, input logic o);
        res_valid = 1'b1; res_w = w; res_l = l; res_ovf = o;
    endtask

    task automatic push(input logic [31:0] w, input logic [5:0] l, input logic o);
        @(negedge clk);
        drive_res(w, l, o);
        m_push(w, l, o);
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic push_rand();
        logic [31:0] w;
        w = $urandom;
        push(w, 6'($countones(w)), 1'($urandom_range(0, 1)));
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk);
        saddress = a; srd = 1'b1;
        @(posedge clk); #1;
        d = sdata_out;
        @(negedge clk);
        srd = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] v);
        @(negedge clk);
        saddress = A_CTRL; sdata_in = v; swr = 1'b1;
        @(negedge clk);
        swr = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(tag, d, exp);
    endtask

    task automatic pop_chk(input string tag);
        rd_chk({tag, "_hw"}, A_HW, m_head_w());
        rd_chk({tag, "_hl"}, A_HL, m_head_l());
        bus_write(32'd1);
        if (sb.size() > 0) void'(sb.pop_front());
    endtask

    initial begin
        logic [31:0] hold;
        logic [31:0] w;

        // Reset state
        #12;
        chk("rst_ready", {31'd0, res_ready}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_sdata", sdata_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd_chk("rst_status", A_STAT, 32'h0000_0100);

        // Single push / pop
        push(32'h1234_5678, 6'd13, 1'b0);
        rd_chk("one_hw", A_HW, 32'h1234_5678);
        rd_chk("one_hl", A_HL, 32'h0000_000D);
        rd_chk("one_status", A_STAT, 32'h0000_0001);
        chk("one_irq", {31'd0, irq}, 32'd1);
        bus_write(32'd1);
        void'(sb.pop_front());
        @(negedge clk);
        chk("one_irq_clr", {31'd0, irq}, 32'd0);
        rd_chk("one_status_empty", A_STAT, m_status());

        // Six back-to-back pushes into a 4-deep FIFO
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            w = $urandom;
            drive_res(w, 6'($countones(w)), 1'(i & 1));
            m_push(w, 6'($countones(w)), 1'(i & 1));
        end
        @(negedge clk);
        res_valid = 1'b0;
        rd_chk("full_status", A_STAT, m_status());
        chk("full_status_lit", m_status(), 32'h0002_0604);
        chk("full_ready", {31'd0, res_ready}, 32'd0);
        chk("full_irq", {31'd0, irq}, 32'd1);
        for (int i = 0; i < 4; i++) pop_chk("drain");
        bus_write(32'd1);
        rd_chk("pop_empty_status", A_STAT, m_status());
        chk("pop_empty_irq", {31'd0, irq}, 32'd0);

        // Push on the same edge as a pop of a full FIFO
        for (int i = 0; i < 4; i++) push_rand();
        @(negedge clk);
        saddress = A_CTRL; sdata_in = 32'd1; swr = 1'b1;
        drive_res(32'hCAFE_F00D, 6'd21, 1'b1);
        void'(sb.pop_front());
        sb.push_back({1'b1, 6'd21, 32'hCAFE_F00D});
        @(negedge clk);
        swr = 1'b0; res_valid = 1'b0;
        rd_chk("pp_status", A_STAT, m_status());
        for (int i = 0; i < 4; i++) pop_chk("pp_drain");

        // Held read strobe captures once while pushes continue
        @(negedge clk);
        saddress = A_STAT; srd = 1'b1;
        hold = m_status();
        @(posedge clk); #1;
        chk("hold_first", sdata_out, hold);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i < 3) begin
                w = $urandom;
                drive_res(w, 6'($countones(w)), 1'b0);
                m_push(w, 6'($countones(w)), 1'b0);
            end else res_valid = 1'b0;
            @(posedge clk); #1;
            chk("hold_stale", sdata_out, hold);
        end
        @(negedge clk);
        srd = 1'b0; res_valid = 1'b0;
        rd_chk("hold_after", A_STAT, m_status());

        // Flush with a same-edge push: nothing kept, nothing dropped
        @(negedge clk);
        saddress = A_CTRL; sdata_in = 32'd2; swr = 1'b1;
        drive_res(32'h0BAD_0BAD, 6'd12, 1'b0);
        sb.delete();
        @(negedge clk);
        swr = 1'b0; res_valid = 1'b0;
        rd_chk("flush_status", A_STAT, m_status());
        rd_chk("flush_hw", A_HW, 32'd0);

        // Drop counter saturation and clear
        for (int i = 0; i < 4; i++) push_rand();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive_res(i, 6'($countones(i)), 1'b0);
            m_push(i, 6'($countones(i)), 1'b0);
        end
        @(negedge clk);
        res_valid = 1'b0;
        rd_chk("sat_status", A_STAT, m_status());
        chk("sat_status_lit", m_status(), 32'h00FF_0604);
        bus_write(32'd4);
        m_sticky = 1'b0; m_dcnt = 0;
        rd_chk("clr_status", A_STAT, m_status());
        chk("clr_status_lit", m_status(), 32'h0000_0204);

        // Reset mid-operation with a held read strobe
        bus_write(32'd2);
        sb.delete();
        for (int i = 0; i < 3; i++) push_rand();
        @(negedge clk);
        saddress = A_HW; srd = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_hw", sdata_out, m_head_w());
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_sdata", sdata_out, 32'd0);
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        chk("mid_rst_ready", {31'd0, res_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        sb.delete(); m_sticky = 1'b0; m_dcnt = 0;
        saddress = A_STAT;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_noread", sdata_out, 32'd0);
        end
        @(negedge clk);
        srd = 1'b0;
        rd_chk("post_rst_status", A_STAT, 32'h0000_0100);
        chk("post_rst_irq", {31'd0, irq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
